// File: rtl/sargantana_icache_checker_pipe_if.sv
// Request/response bundle of the pipelined icache tag checker.
// The master side issues tag-compare requests and consumes responses; the checker is the slave.
interface sargantana_icache_checker_pipe_if #(
    parameter int N_WAYS  = 4,
    parameter int TAG_W   = 20,
    parameter int LINE_W  = 256,
    parameter int FETCH_W = 128,
    parameter int CNT_W   = 32,
    parameter int OFF_W   = (LINE_W / FETCH_W > 1) ? $clog2(LINE_W / FETCH_W) : 1
);
    // Both sides use valid/ready: a transfer happens on a rising clock edge where valid and
    // ready are both 1. Once valid is raised, it and its payload stay stable until that transfer.
    logic                       flush_i;
    logic                       req_valid_i;
    logic                       req_ready_o;
    logic [TAG_W-1:0]           req_tag_i;
    logic [OFF_W-1:0]           req_off_i;
    logic [N_WAYS-1:0]          way_valid_i;
    logic [N_WAYS*TAG_W-1:0]    read_tags_i;
    logic [N_WAYS*LINE_W-1:0]   data_rd_i;
    logic                       rsp_valid_o;
    logic                       rsp_ready_i;
    logic                       rsp_hit_o;
    logic [N_WAYS-1:0]          rsp_way_o;
    logic                       rsp_multihit_o;
    logic [FETCH_W-1:0]         rsp_data_o;
    logic [CNT_W-1:0]           hit_cnt_o;
    logic [CNT_W-1:0]           miss_cnt_o;
    logic [CNT_W-1:0]           mhit_cnt_o;

    modport master (
        output flush_i, req_valid_i, req_tag_i, req_off_i, way_valid_i, read_tags_i,
               data_rd_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_multihit_o, rsp_data_o,
               hit_cnt_o, miss_cnt_o, mhit_cnt_o
    );

    modport slave (
        input  flush_i, req_valid_i, req_tag_i, req_off_i, way_valid_i, read_tags_i,
               data_rd_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_multihit_o, rsp_data_o,
               hit_cnt_o, miss_cnt_o, mhit_cnt_o
    );
endinterface

// File: rtl/sargantana_icache_checker_pipe.sv
// Two-stage icache tag checker: stage 1 compares tags and picks each way's chunk, stage 2 resolves the way.
// Define SARGANTANA_ICACHE_CHK_PERF_EN to build the saturating hit/miss/multi-hit counters.
module sargantana_icache_checker_pipe #(
    parameter int N_WAYS  = 4,
    parameter int TAG_W   = 20,
    parameter int LINE_W  = 256,
    parameter int FETCH_W = 128,
    parameter int CNT_W   = 32
) (
    input logic                              clk_i,
    input logic                              rstn_i,
    sargantana_icache_checker_pipe_if.slave  bus
);
    localparam int N_CHUNK = LINE_W / FETCH_W;

    logic               s1_valid;
    logic               s2_valid;
    logic               s2_adv;
    logic               req_ready;
    logic               accept;
    int                 off_idx;
    logic [N_WAYS-1:0]  hit_in;
    logic [FETCH_W-1:0] chunk_in [N_WAYS];
    logic [N_WAYS-1:0]  s1_hit;
    logic [FETCH_W-1:0] s1_chunk [N_WAYS];
    logic               found;
    logic [N_WAYS-1:0]  sel_way;
    logic               sel_multi;
    logic [FETCH_W-1:0] sel_data;
    logic               rsp_hit;
    logic [N_WAYS-1:0]  rsp_way;
    logic               rsp_multi;
    logic [FETCH_W-1:0] rsp_data;

    // Stage 1 refills whenever it is empty or its entry moves on; flush blocks intake for that cycle.
    assign s2_adv    = !s2_valid || bus.rsp_ready_i;
    assign req_ready = rstn_i && !bus.flush_i && (!s1_valid || s2_adv);
    assign accept    = bus.req_valid_i && req_ready;

    assign bus.req_ready_o = req_ready;

    always_comb begin
        off_idx = (N_CHUNK > 1) ? int'(bus.req_off_i) : 0;
        hit_in  = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            hit_in[w]   = bus.way_valid_i[w] && (bus.read_tags_i[w*TAG_W +: TAG_W] == bus.req_tag_i);
            chunk_in[w] = bus.data_rd_i[w*LINE_W + off_idx*FETCH_W +: FETCH_W];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid <= 1'b0;
            s1_hit   <= '0;
        end else begin
            if (bus.flush_i) begin
                s1_valid <= 1'b0;
            end else if (accept) begin
                s1_valid <= 1'b1;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
            if (accept) begin
                s1_hit <= hit_in;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int w = 0; w < N_WAYS; w++) begin
                s1_chunk[w] <= chunk_in[w];
            end
        end
    end

    // Lowest-index hit wins; any later hit marks the entry as multi-hit.
    always_comb begin
        found     = 1'b0;
        sel_way   = '0;
        sel_multi = 1'b0;
        sel_data  = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (s1_hit[w]) begin
                if (found) begin
                    sel_multi = 1'b1;
                end else begin
                    sel_way[w] = 1'b1;
                    sel_data   = s1_chunk[w];
                end
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s2_valid  <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_way   <= '0;
            rsp_multi <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (bus.flush_i) begin
                s2_valid <= 1'b0;
            end else if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_adv && s1_valid) begin
                rsp_hit   <= found;
                rsp_way   <= sel_way;
                rsp_multi <= sel_multi;
                rsp_data  <= sel_data;
            end
        end
    end

    assign bus.rsp_valid_o    = s2_valid;
    assign bus.rsp_hit_o      = rsp_hit;
    assign bus.rsp_way_o      = rsp_way;
    assign bus.rsp_multihit_o = rsp_multi;
    assign bus.rsp_data_o     = rsp_data;

`ifdef SARGANTANA_ICACHE_CHK_PERF_EN
    logic             rsp_fire;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] mhit_cnt;

    // An entry dropped by a flush in the same cycle is never counted.
    assign rsp_fire = s2_valid && bus.rsp_ready_i && !bus.flush_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            mhit_cnt <= '0;
        end else if (rsp_fire) begin
            if (rsp_hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (!rsp_hit && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
            if (rsp_multi && (mhit_cnt != '1)) begin
                mhit_cnt <= mhit_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.hit_cnt_o  = hit_cnt;
    assign bus.miss_cnt_o = miss_cnt;
    assign bus.mhit_cnt_o = mhit_cnt;
`else
    assign bus.hit_cnt_o  = '0;
    assign bus.miss_cnt_o = '0;
    assign bus.mhit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sargantana_icache_checker_pipe.sv
// Directed bench for sargantana_icache_checker_pipe: queued expected responses, decoupled monitor.
// Counter expectations follow SARGANTANA_ICACHE_CHK_PERF_EN (zero when it is undefined).
module tb_sargantana_icache_checker_pipe;
    localparam int N_WAYS  = 4;
    localparam int TAG_W   = 20;
    localparam int LINE_W  = 256;
    localparam int FETCH_W = 128;
    localparam int CNT_W   = 4;
    localparam int RSP_W   = 1 + N_WAYS + 1 + FETCH_W;
`ifdef SARGANTANA_ICACHE_CHK_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk = ~clk;

    sargantana_icache_checker_pipe_if #(
        .N_WAYS(N_WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W), .FETCH_W(FETCH_W), .CNT_W(CNT_W)
    ) bus ();

    sargantana_icache_checker_pipe #(
        .N_WAYS(N_WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W), .FETCH_W(FETCH_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn_i),
        .bus   (bus)
    );

    logic [RSP_W-1:0] exp_q[$];
    logic [RSP_W-1:0] got;
    logic [RSP_W-1:0] exp_r;
    int  total = 0;
    int  bad = 0;
    int  acc_cnt = 0;
    bit  mon_en = 1'b1;
    bit  done4 = 1'b0;

    task automatic check(input string name, input logic [FETCH_W-1:0] act, input logic [FETCH_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] cnt_exp(input int v);
        return PERF ? CNT_W'(v) : '0;
    endfunction

    function automatic logic [FETCH_W-1:0] pat(input logic [31:0] seed, input int w, input int k);
        logic [7:0] id;
        id = 8'((w << 4) | k);
        return {seed, 24'hC0DE00, id, ~seed, 24'h5A5A00, id};
    endfunction

    // Drive one request, hold it until accepted, and queue its hand-specified response.
    task automatic issue(input logic [TAG_W-1:0] tag, input logic [N_WAYS*TAG_W-1:0] rtags,
                         input logic [N_WAYS-1:0] vld, input logic off, input logic [31:0] seed,
                         input logic exp_hit, input logic [N_WAYS-1:0] exp_way,
                         input logic exp_multi, input int exp_idx, output int tries);
        logic [RSP_W-1:0] e;
        bit accepted;
        bus.req_tag_i   = tag;
        bus.read_tags_i = rtags;
        bus.way_valid_i = vld;
        bus.req_off_i   = off;
        for (int w = 0; w < N_WAYS; w++) begin
            for (int k = 0; k < 2; k++) begin
                bus.data_rd_i[w*LINE_W + k*FETCH_W +: FETCH_W] = pat(seed, w, k);
            end
        end
        e = {exp_hit, exp_way, exp_multi, exp_hit ? pat(seed, exp_idx, int'(off)) : {FETCH_W{1'b0}}};
        bus.req_valid_i = 1'b1;
        accepted = 1'b0;
        tries = 0;
        while (!accepted && tries < 50) begin
            @(negedge clk);
            tries++;
            if (bus.req_ready_o) begin
                exp_q.push_back(e);
                acc_cnt++;
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid_i = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", FETCH_W'(exp_q.size()), '0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn_i && mon_en && bus.rsp_valid_o) begin
            got = {bus.rsp_hit_o, bus.rsp_way_o, bus.rsp_multihit_o, bus.rsp_data_o};
            if (bus.rsp_ready_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: got %0h expected no response", got);
                end else begin
                    exp_r = exp_q.pop_front();
                    if (got !== exp_r) begin
                        bad++;
                        $display("FAIL rsp_compare: got %0h expected %0h", got, exp_r);
                    end
                end
            end else if (exp_q.size() != 0) begin
                total++;
                if (got !== exp_q[0]) begin
                    bad++;
                    $display("FAIL rsp_hold: got %0h expected %0h", got, exp_q[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tries;
        int acc0;
        int n;
        logic [N_WAYS*TAG_W-1:0] rt;

        bus.flush_i = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_tag_i = '0;
        bus.req_off_i = '0;
        bus.way_valid_i = '0;
        bus.read_tags_i = '0;
        bus.data_rd_i = '0;
        bus.rsp_ready_i = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", FETCH_W'(bus.rsp_valid_o), '0);
        check("rst_rsp_data", bus.rsp_data_o, '0);
        check("rst_hit_cnt", FETCH_W'(bus.hit_cnt_o), '0);
        rstn_i = 1'b1;
        @(negedge clk);
        check("rst_req_ready", FETCH_W'(bus.req_ready_o), 1);
        @(posedge clk);
        #1;

        // 1: single hit in way 2, offset 1, two-cycle latency
        issue(20'h12345, {20'h0AAAA, 20'h12345, 20'h11111, 20'h22222}, 4'b1111, 1'b1, 32'h1111_0001,
              1'b1, 4'b0100, 1'b0, 2, tries);
        @(negedge clk);
        check("t1_lat_cycle1", FETCH_W'(bus.rsp_valid_o), 0);
        @(negedge clk);
        check("t1_lat_cycle2", FETCH_W'(bus.rsp_valid_o), 1);
        wait_drain();
        check("t1_hit_cnt", FETCH_W'(bus.hit_cnt_o), FETCH_W'(cnt_exp(1)));

        // 2: tag matches an invalid way -> miss
        issue(20'h0ABCD, {20'h00001, 20'h00002, 20'h0ABCD, 20'h00003}, 4'b1101, 1'b0, 32'h2222_0002,
              1'b0, 4'b0000, 1'b0, 0, tries);
        wait_drain();
        check("t2_miss_cnt", FETCH_W'(bus.miss_cnt_o), FETCH_W'(cnt_exp(1)));

        // 3: ways 1 and 3 both hit -> way 1 selected, multi-hit
        issue(20'h55555, {20'h55555, 20'h00004, 20'h55555, 20'h00006}, 4'b1111, 1'b0, 32'h3333_0003,
              1'b1, 4'b0010, 1'b1, 1, tries);
        wait_drain();
        check("t3_hit_cnt", FETCH_W'(bus.hit_cnt_o), FETCH_W'(cnt_exp(2)));
        check("t3_mhit_cnt", FETCH_W'(bus.mhit_cnt_o), FETCH_W'(cnt_exp(1)));

        // 4: consumer stalls for 5 cycles while 3 requests are offered
        bus.rsp_ready_i = 1'b0;
        acc0 = acc_cnt;
        done4 = 1'b0;
        fork
            begin
                int t;
                issue(20'h00A0A, {20'h00000, 20'h00000, 20'h00000, 20'h00A0A}, 4'b1111, 1'b1,
                      32'h4444_000A, 1'b1, 4'b0001, 1'b0, 0, t);
                issue(20'h0B0B0, {20'h0B0B0, 20'h00000, 20'h00000, 20'h00000}, 4'b1111, 1'b0,
                      32'h4444_000B, 1'b1, 4'b1000, 1'b0, 3, t);
                issue(20'h0C0C0, {20'h00000, 20'h0C0C0, 20'h00000, 20'h00000}, 4'b1111, 1'b1,
                      32'h4444_000C, 1'b1, 4'b0100, 1'b0, 2, t);
                done4 = 1'b1;
            end
        join_none
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t4_req_ready_low", FETCH_W'(bus.req_ready_o), 0);
        check("t4_accepted_2", FETCH_W'(acc_cnt - acc0), 2);
        check("t4_rsp_valid_held", FETCH_W'(bus.rsp_valid_o), 1);
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stream", FETCH_W'(bus.rsp_valid_o), 1);
        end
        n = 0;
        while (!done4 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("t4_driver_done", FETCH_W'(done4), 1);
        wait_drain();
        check("t4_hit_cnt", FETCH_W'(bus.hit_cnt_o), FETCH_W'(cnt_exp(5)));

        // 5: flush with two requests in flight
        bus.rsp_ready_i = 1'b0;
        issue(20'h0D0D0, {20'h00000, 20'h00000, 20'h00000, 20'h0D0D0}, 4'b1111, 1'b0, 32'h5555_000D,
              1'b1, 4'b0001, 1'b0, 0, tries);
        issue(20'h0E0E0, {20'h00000, 20'h00000, 20'h0E0E0, 20'h00000}, 4'b1111, 1'b1, 32'h5555_000E,
              1'b1, 4'b0010, 1'b0, 1, tries);
        @(negedge clk);
        check("t5_inflight", FETCH_W'(bus.rsp_valid_o), 1);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        exp_q.delete();
        bus.req_tag_i = 20'h0F0F0;
        bus.read_tags_i = {20'h0F0F0, 20'h00000, 20'h00000, 20'h00000};
        bus.req_valid_i = 1'b1;
        @(negedge clk);
        check("t5_flush_ready", FETCH_W'(bus.req_ready_o), 0);
        @(posedge clk);
        #1;
        check("t5_flushed_valid", FETCH_W'(bus.rsp_valid_o), 0);
        bus.flush_i = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        check("t5_hit_cnt_kept", FETCH_W'(bus.hit_cnt_o), FETCH_W'(cnt_exp(5)));
        issue(20'h07777, {20'h00001, 20'h00002, 20'h00003, 20'h00004}, 4'b1111, 1'b1, 32'h5555_0007,
              1'b0, 4'b0000, 1'b0, 0, tries);
        check("t5_accept_next", FETCH_W'(tries), 1);
        wait_drain();
        check("t5_miss_cnt", FETCH_W'(bus.miss_cnt_o), FETCH_W'(cnt_exp(2)));
        check("t5_hit_cnt", FETCH_W'(bus.hit_cnt_o), FETCH_W'(cnt_exp(5)));

        // 6: 20 hits saturate a 4-bit hit counter at 15
        for (int i = 0; i < 20; i++) begin
            rt = '0;
            rt[(i % 4)*TAG_W +: TAG_W] = 20'h3C3C3;
            issue(20'h3C3C3, rt, 4'b1111, 1'(i % 2), 32'h6600_0000 + 32'(i),
                  1'b1, 4'(1 << (i % 4)), 1'b0, i % 4, tries);
        end
        wait_drain();
        check("t6_hit_sat", FETCH_W'(bus.hit_cnt_o), FETCH_W'(cnt_exp(15)));
        check("t6_mhit_cnt", FETCH_W'(bus.mhit_cnt_o), FETCH_W'(cnt_exp(1)));
        check("t6_miss_cnt", FETCH_W'(bus.miss_cnt_o), FETCH_W'(cnt_exp(2)));

        // 6b: reset asserted while responses stream
        mon_en = 1'b0;
        bus.req_tag_i = 20'h13579;
        bus.read_tags_i = {20'h00000, 20'h00000, 20'h00000, 20'h13579};
        bus.way_valid_i = 4'b1111;
        bus.req_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_pre_valid", FETCH_W'(bus.rsp_valid_o), 1);
        @(posedge clk);
        #2;
        rstn_i = 1'b0;
        #1;
        check("t6_rst_valid", FETCH_W'(bus.rsp_valid_o), 0);
        check("t6_rst_hit", FETCH_W'(bus.rsp_hit_o), 0);
        check("t6_rst_way", FETCH_W'(bus.rsp_way_o), 0);
        check("t6_rst_data", bus.rsp_data_o, '0);
        check("t6_rst_hit_cnt", FETCH_W'(bus.hit_cnt_o), '0);
        check("t6_rst_miss_cnt", FETCH_W'(bus.miss_cnt_o), '0);
        check("t6_rst_ready", FETCH_W'(bus.req_ready_o), 0);
        bus.req_valid_i = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn_i = 1'b1;
        @(negedge clk);
        check("t6_post_ready", FETCH_W'(bus.req_ready_o), 1);
        check("t6_post_valid", FETCH_W'(bus.rsp_valid_o), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_leak", FETCH_W'(bus.rsp_valid_o), 0);
        end
        mon_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
